// File: rtl/pipe_hazard_tracker.sv
// Register-hazard tracker: shift register of in-flight destination writes feeding
// operand forwarding, the ID-stage load-use stall and a saturating stall counter.
module pipe_hazard_tracker #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int STAGES = 3,
    localparam int SW    = $clog2(STAGES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     freeze,
    input  logic [STAGES-1:0]        flush,
    input  logic                     id_valid,
    input  logic [RA_W-1:0]          id_rs_addr,
    input  logic [RA_W-1:0]          id_rt_addr,
    input  logic                     id_rs_used,
    input  logic                     id_rt_used,
    input  logic                     id_wr_en,
    input  logic [RA_W-1:0]          id_wr_addr,
    input  logic [SW-1:0]            id_ready_stage,
    input  logic [XLEN*STAGES-1:0]   stage_data,
    output logic                     stall,
    output logic                     rs_fwd_hit,
    output logic                     rt_fwd_hit,
    output logic [XLEN-1:0]          rs_fwd_data,
    output logic [XLEN-1:0]          rt_fwd_data,
    output logic [31:0]              stall_cnt
);

    logic [STAGES-1:0]           ent_valid;
    logic [STAGES-1:0]           ent_wr_en;
    logic [STAGES-1:0][RA_W-1:0] ent_addr;
    logic [STAGES-1:0][SW-1:0]   ent_rdy;

    // Source 0 is rs, source 1 is rt.
    logic [1:0][RA_W-1:0] src_addr;
    logic [1:0]           src_used;
    logic [1:0]           src_found;
    logic [1:0][SW-1:0]   src_idx;
    logic [1:0]           src_hit;
    logic [1:0]           src_wait;
    logic [1:0][XLEN-1:0] src_data;

    assign src_addr = {id_rt_addr, id_rs_addr};
    assign src_used = {id_rt_used, id_rs_used};

    // Scan oldest to youngest so the youngest match is the one left standing;
    // an unready youngest match blocks any older, ready entry.
    always_comb begin
        src_found = '0;
        src_idx   = '0;
        src_hit   = '0;
        src_wait  = '0;
        src_data  = '0;
        for (int s = 0; s < 2; s++) begin
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (id_valid && src_used[s] && (src_addr[s] != '0) &&
                    ent_valid[k] && ent_wr_en[k] && (ent_addr[k] == src_addr[s])) begin
                    src_found[s] = 1'b1;
                    src_idx[s]   = SW'(k);
                end
            end
            if (src_found[s]) begin
                if (src_idx[s] >= ent_rdy[src_idx[s]]) begin
                    src_hit[s]  = 1'b1;
                    src_data[s] = stage_data[int'(src_idx[s]) * XLEN +: XLEN];
                end else begin
                    src_wait[s] = 1'b1;
                end
            end
        end
    end

    assign stall       = |src_wait;
    assign rs_fwd_hit  = src_hit[0];
    assign rt_fwd_hit  = src_hit[1];
    assign rs_fwd_data = src_data[0];
    assign rt_fwd_data = src_data[1];

    // A stalled ID instruction enters as a bubble; flush[0] does the same, so both together are harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent_valid <= '0;
            ent_wr_en <= '0;
            ent_addr  <= '0;
            ent_rdy   <= '0;
            stall_cnt <= '0;
        end else if (!freeze) begin
            for (int k = 1; k < STAGES; k++) begin
                ent_valid[k] <= ent_valid[k-1] & ~flush[k];
                ent_wr_en[k] <= ent_wr_en[k-1];
                ent_addr[k]  <= ent_addr[k-1];
                ent_rdy[k]   <= ent_rdy[k-1];
            end
            ent_valid[0] <= id_valid & ~flush[0] & ~stall;
            ent_wr_en[0] <= id_wr_en;
            ent_addr[0]  <= id_wr_addr;
            ent_rdy[0]   <= id_ready_stage;
            if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// Bench for pipe_hazard_tracker: a directed cycle table, hand-written freeze and
// reset sequences, then random traffic checked against a queue-based model.
module tb_pipe_hazard_tracker;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic [2:0]  flush;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr;
    logic        id_rs_used, id_rt_used;
    logic        id_wr_en;
    logic [4:0]  id_wr_addr;
    logic [1:0]  id_ready_stage;
    logic [95:0] stage_data;
    logic        stall, rs_fwd_hit, rt_fwd_hit;
    logic [31:0] rs_fwd_data, rt_fwd_data, stall_cnt;

    pipe_hazard_tracker #(.XLEN(32), .RA_W(5), .STAGES(3)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
        .id_valid(id_valid), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr_en(id_wr_en),
        .id_wr_addr(id_wr_addr), .id_ready_stage(id_ready_stage), .stage_data(stage_data),
        .stall(stall), .rs_fwd_hit(rs_fwd_hit), .rt_fwd_hit(rt_fwd_hit),
        .rs_fwd_data(rs_fwd_data), .rt_fwd_data(rt_fwd_data), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit [2:0]  fl;
        bit        iv;
        bit [4:0]  rs;
        bit        rsu;
        bit [4:0]  rt;
        bit        rtu;
        bit        we;
        bit [4:0]  wa;
        bit [1:0]  rdy;
        bit [31:0] d0, d1, d2;
        bit        st, rsh, rth;
        bit [31:0] rsd, rtd, cnt;
    } vec_t;

    typedef struct {
        bit v;
        bit we;
        bit [4:0] a;
        int rdy;
    } ment_t;

    ment_t     mq[$];
    bit [31:0] mcnt;
    int        total = 0;
    int        bad = 0;
    int        cyc = 0;
    vec_t      tbl[15];
    vec_t      nv;
    bit        s_stall, s_rsh, s_rth;
    bit [31:0] s_rsd, s_rtd, s_cnt;
    bit [31:0] frz_cnt;

    function automatic vec_t mk(bit [2:0] fl, bit iv, bit [4:0] rs, bit rsu, bit [4:0] rt, bit rtu,
                                bit we, bit [4:0] wa, bit [1:0] rdy,
                                bit [31:0] d0, bit [31:0] d1, bit [31:0] d2,
                                bit st, bit rsh, bit rth, bit [31:0] rsd, bit [31:0] rtd, bit [31:0] cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu;
        v.we = we; v.wa = wa; v.rdy = rdy; v.d0 = d0; v.d1 = d1; v.d2 = d2;
        v.st = st; v.rsh = rsh; v.rth = rth; v.rsd = rsd; v.rtd = rtd; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // First matching entry from the youngest end decides everything for a source.
    function automatic void src_eval(input bit [4:0] a, input bit used,
                                     output bit hit, output bit wt, output bit [31:0] d);
        hit = 1'b0; wt = 1'b0; d = 32'h0;
        if (id_valid !== 1'b1 || !used || a == 5'd0) return;
        for (int k = 0; k < 3; k++) begin
            if (mq[k].v && mq[k].we && mq[k].a == a) begin
                if (k >= mq[k].rdy) begin
                    hit = 1'b1;
                    d = stage_data[k*32 +: 32];
                end else begin
                    wt = 1'b1;
                end
                return;
            end
        end
    endfunction

    task automatic model_reset();
        ment_t e;
        e.v = 1'b0; e.we = 1'b0; e.a = 5'd0; e.rdy = 0;
        mq.delete();
        repeat (3) mq.push_back(e);
        mcnt = 32'h0;
    endtask

    task automatic model_update(input bit st);
        ment_t n;
        ment_t old;
        if (rst_n !== 1'b1) begin
            model_reset();
        end else if (freeze !== 1'b1) begin
            n.v = !st && (id_valid === 1'b1);
            n.we = id_wr_en;
            n.a = id_wr_addr;
            n.rdy = int'(id_ready_stage);
            mq.push_front(n);
            old = mq.pop_back();
            for (int k = 0; k < 3; k++) if (flush[k]) mq[k].v = 1'b0;
            if (st && mcnt != 32'hFFFF_FFFF) mcnt = mcnt + 32'd1;
        end
    endtask

    task automatic set_in(input bit iv, input bit [4:0] rs, input bit rsu, input bit [4:0] rt,
                          input bit rtu, input bit we, input bit [4:0] wa, input bit [1:0] rdy);
        id_valid = iv; id_rs_addr = rs; id_rs_used = rsu; id_rt_addr = rt; id_rt_used = rtu;
        id_wr_en = we; id_wr_addr = wa; id_ready_stage = rdy;
    endtask

    // Sample at the falling edge, compare, advance the model, then cross the rising edge.
    task automatic step(input bit use_tbl, input vec_t v);
        bit rh, rw, th, tw, est;
        bit [31:0] rd, td;
        @(negedge clk);
        src_eval(id_rs_addr, id_rs_used, rh, rw, rd);
        src_eval(id_rt_addr, id_rt_used, th, tw, td);
        est = rw | tw;
        s_stall = stall; s_rsh = rs_fwd_hit; s_rth = rt_fwd_hit;
        s_rsd = rs_fwd_data; s_rtd = rt_fwd_data; s_cnt = stall_cnt;
        if (use_tbl) begin
            chk("tbl_stall", 32'(stall), 32'(v.st));
            chk("tbl_rs_hit", 32'(rs_fwd_hit), 32'(v.rsh));
            chk("tbl_rt_hit", 32'(rt_fwd_hit), 32'(v.rth));
            chk("tbl_rs_data", rs_fwd_data, v.rsd);
            chk("tbl_rt_data", rt_fwd_data, v.rtd);
            chk("tbl_stall_cnt", stall_cnt, v.cnt);
        end else begin
            chk("mdl_stall", 32'(stall), 32'(est));
            chk("mdl_rs_hit", 32'(rs_fwd_hit), 32'(rh));
            chk("mdl_rt_hit", 32'(rt_fwd_hit), 32'(th));
            chk("mdl_rs_data", rs_fwd_data, rd);
            chk("mdl_rt_data", rt_fwd_data, td);
            chk("mdl_stall_cnt", stall_cnt, mcnt);
        end
        model_update(est);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        //            fl     iv rs  u  rt  u  we wa rdy d0     d1       d2     st rh th rsd      rtd      cnt
        tbl[0]  = mk(3'b000, 1, 1,  1, 2,  1, 1, 3, 0, 0,     0,       0,     0, 0, 0, 0,       0,       0);
        tbl[1]  = mk(3'b000, 1, 3,  1, 0,  1, 1, 8, 0, 'h11,  0,       0,     0, 1, 0, 'h11,    0,       0);
        tbl[2]  = mk(3'b000, 1, 29, 1, 0,  0, 1, 4, 1, 0,     0,       0,     0, 0, 0, 0,       0,       0);
        tbl[3]  = mk(3'b000, 1, 4,  1, 4,  1, 1, 5, 0, 0,     0,       0,     1, 0, 0, 0,       0,       0);
        tbl[4]  = mk(3'b000, 1, 4,  1, 4,  1, 1, 5, 0, 0,     'hDEAD,  0,     0, 1, 1, 'hDEAD,  'hDEAD,  1);
        tbl[5]  = mk(3'b000, 1, 9,  1, 0,  0, 1, 0, 0, 0,     0,       0,     0, 0, 0, 0,       0,       1);
        tbl[6]  = mk(3'b000, 1, 0,  1, 0,  1, 1, 7, 0, 'h77,  0,       0,     0, 0, 0, 0,       0,       1);
        tbl[7]  = mk(3'b000, 1, 10, 1, 11, 1, 1, 7, 0, 0,     0,       0,     0, 0, 0, 0,       0,       1);
        tbl[8]  = mk(3'b000, 1, 7,  1, 7,  1, 1, 7, 1, 'hA,   'hB,     0,     0, 1, 1, 'hA,     'hA,     1);
        tbl[9]  = mk(3'b000, 1, 7,  1, 12, 1, 1, 20,0, 1,     'hB,     'hC,   1, 0, 0, 0,       0,       1);
        tbl[10] = mk(3'b000, 1, 13, 1, 14, 1, 1, 6, 0, 0,     0,       0,     0, 0, 0, 0,       0,       2);
        tbl[11] = mk(3'b010, 0, 6,  1, 0,  0, 0, 0, 0, 'h66,  0,       0,     0, 0, 0, 0,       0,       2);
        tbl[12] = mk(3'b000, 1, 6,  1, 7,  1, 0, 0, 0, 0,     'h66,    'h77,  0, 0, 0, 0,       0,       2);
        tbl[13] = mk(3'b001, 1, 15, 1, 0,  0, 1, 9, 0, 0,     0,       0,     0, 0, 0, 0,       0,       2);
        tbl[14] = mk(3'b000, 1, 9,  1, 0,  0, 0, 0, 0, 'h99,  0,       0,     0, 0, 0, 0,       0,       2);
        nv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        model_reset();
        rst_n = 1'b0; freeze = 1'b0; flush = 3'b000; stage_data = '0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state: a consumer of $1 and $2 must see nothing.
        rst_n = 1'b1;
        set_in(1, 1, 1, 2, 1, 0, 0, 0);
        step(0, nv);
        chk("rst_stall", 32'(s_stall), 32'd0);
        chk("rst_rs_hit", 32'(s_rsh), 32'd0);
        chk("rst_rt_hit", 32'(s_rth), 32'd0);
        chk("rst_rs_data", s_rsd, 32'd0);
        chk("rst_cnt", s_cnt, 32'd0);

        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, nv);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            flush = tbl[i].fl;
            set_in(tbl[i].iv, tbl[i].rs, tbl[i].rsu, tbl[i].rt, tbl[i].rtu, tbl[i].we, tbl[i].wa, tbl[i].rdy);
            stage_data = {tbl[i].d2, tbl[i].d1, tbl[i].d0};
            step(1, tbl[i]);
        end
        flush = 3'b000;
        stage_data = '0;

        // Freeze while a load-use stall is pending.
        set_in(1, 0, 0, 0, 0, 1, 4, 1);
        step(0, nv);
        frz_cnt = mcnt;
        freeze = 1'b1;
        set_in(1, 4, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, nv);
            chk("frz_stall", 32'(s_stall), 32'd1);
            chk("frz_cnt_hold", s_cnt, frz_cnt);
        end
        freeze = 1'b0;
        step(0, nv);
        chk("unfrz_stall", 32'(s_stall), 32'd1);
        stage_data[63:32] = 32'h5A5A;
        step(0, nv);
        chk("unfrz_rs_hit", 32'(s_rsh), 32'd1);
        chk("unfrz_rs_data", s_rsd, 32'h5A5A);
        chk("unfrz_cnt", s_cnt, frz_cnt + 32'd1);
        stage_data = '0;

        // Reset mid-operation: build stall_cnt = 5 and three live entries, then pulse reset.
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, nv);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0, 0, 1, 4, 1);
            step(0, nv);
            set_in(1, 4, 1, 4, 1, 0, 0, 0);
            step(0, nv);
            step(0, nv);
        end
        set_in(1, 0, 0, 0, 0, 1, 1, 0);
        step(0, nv);
        set_in(1, 0, 0, 0, 0, 1, 2, 0);
        step(0, nv);
        set_in(1, 0, 0, 0, 0, 1, 3, 1);
        step(0, nv);
        chk("pre_rst_cnt", s_cnt, 32'd5);
        rst_n = 1'b0;
        set_in(1, 3, 1, 2, 1, 0, 0, 0);
        step(0, nv);
        chk("pre_rst_stall", 32'(s_stall), 32'd1);
        rst_n = 1'b1;
        step(0, nv);
        chk("post_rst_stall", 32'(s_stall), 32'd0);
        chk("post_rst_rs_hit", 32'(s_rsh), 32'd0);
        chk("post_rst_rt_hit", 32'(s_rth), 32'd0);
        chk("post_rst_cnt", s_cnt, 32'd0);

        // Random traffic on a small register set so hazards are frequent.
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            freeze = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            set_in($urandom_range(0, 6) != 0,
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   2'($urandom_range(0, 2)));
            stage_data = {$urandom, $urandom, $urandom};
            step(0, nv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
